// File: rtl/ram_fifo_pkg.sv
// Shared constants and RAM-port op encoding for the RAM-backed streaming FIFO.
package ram_fifo_pkg;

    localparam int ADDR_W_DEF = 6;
    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 2 ** ADDR_W_DEF;

    // Entries of headroom below full at which almost_full asserts
    localparam int AF_MARGIN = 4;

    typedef enum logic [1:0] {
        OP_IDLE = 2'd0,
        OP_WR   = 2'd1,
        OP_RD   = 2'd2
    } ram_op_e;

endpackage

// File: rtl/ram_port_arb.sv
// Single RAM port arbiter: picks write, read or idle each cycle and derives s_ready.
module ram_port_arb
    import ram_fifo_pkg::*;
(
    input  logic    s_valid,
    input  logic    wr_room,
    input  logic    rd_elig,
    input  logic    prio,
    input  logic    flush,
    output ram_op_e op,
    output logic    s_ready
);

    // A pending read with read priority steals the port, so s_ready never looks at s_valid
    assign s_ready = wr_room && !flush && !(rd_elig && prio);

    always_comb begin
        op = OP_IDLE;
        if (s_valid && s_ready)
            op = OP_WR;
        else if (rd_elig && !flush)
            op = OP_RD;
    end

endmodule

// File: rtl/ram_stream_fifo_ctrl.sv
// Streaming FIFO controller over a 64x8 single-port RAM with a registered output stage.
// Optional RAM_STREAM_FIFO_LEVEL_EN adds level and almost_full status outputs.
module ram_stream_fifo_ctrl
    import ram_fifo_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
`ifdef RAM_STREAM_FIFO_LEVEL_EN
    output logic [ADDR_W:0]   level,
    output logic              almost_full,
`endif
    input  logic [DATA_W-1:0] ram_dout
);

    localparam int              DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   count;
    logic              prio;
    logic              rd_elig, wr_room;
    ram_op_e           op;

    assign rd_elig = (count != '0) && (!m_valid || m_ready);
    assign wr_room = (count != FULL_CNT);

    ram_port_arb u_arb (
        .s_valid (s_valid),
        .wr_room (wr_room),
        .rd_elig (rd_elig),
        .prio    (prio),
        .flush   (flush),
        .op      (op),
        .s_ready (s_ready)
    );

    assign ram_we   = (op == OP_WR);
    assign ram_addr = (op == OP_WR) ? wr_ptr : rd_ptr;
    assign ram_din  = s_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
            prio    <= 1'b0;
        end else if (flush) begin
            // Output byte is dropped even if it is being accepted this cycle
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            m_valid <= 1'b0;
            prio    <= 1'b0;
        end else begin
            case (op)
                OP_WR: begin
                    wr_ptr <= wr_ptr + 1'b1;
                    count  <= count + 1'b1;
                    prio   <= 1'b1;
                    if (m_valid && m_ready)
                        m_valid <= 1'b0;
                end
                OP_RD: begin
                    m_data  <= ram_dout;
                    m_valid <= 1'b1;
                    rd_ptr  <= rd_ptr + 1'b1;
                    count   <= count - 1'b1;
                    prio    <= 1'b0;
                end
                default: begin
                    if (m_valid && m_ready)
                        m_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef RAM_STREAM_FIFO_LEVEL_EN
    localparam logic [ADDR_W:0] AF_THRESH = (ADDR_W+1)'(DEPTH - AF_MARGIN);

    assign level       = count + {{ADDR_W{1'b0}}, m_valid};
    assign almost_full = (count >= AF_THRESH);
`endif

endmodule

// File: tb/tb_ram_stream_fifo_ctrl.sv
// Directed bench for ram_stream_fifo_ctrl with a behavioural 64x8 RAM and an in-order scoreboard.
module tb_ram_stream_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush, s_valid, s_ready, m_valid, m_ready, ram_we;
    logic [7:0] s_data, m_data, ram_din, ram_dout;
    logic [5:0] ram_addr;
`ifdef RAM_STREAM_FIFO_LEVEL_EN
    logic [6:0] level;
    logic       almost_full;
`endif

    logic [7:0] mem [64];

    int checks = 0;
    int passed = 0;

    logic       o_sready, o_we, o_mv, acc;
    logic [5:0] o_addr;
    logic [7:0] o_md;
    logic [5:0] wp;
    logic [7:0] q[$];
    int         n_in;

    always #5 clk = ~clk;

    always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_din;
    assign ram_dout = mem[ram_addr];

    ram_stream_fifo_ctrl #(.ADDR_W(6), .DATA_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_din     (ram_din),
`ifdef RAM_STREAM_FIFO_LEVEL_EN
        .level       (level),
        .almost_full (almost_full),
`endif
        .ram_dout    (ram_dout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One clock cycle: drive at negedge, sample after settling, score the handshakes
    task automatic cyc(input logic sv, input logic [7:0] sd, input logic mr, input logic fl);
        @(negedge clk);
        s_valid = sv; s_data = sd; m_ready = mr; flush = fl;
        #1;
        o_sready = s_ready; o_we = ram_we; o_addr = ram_addr;
        o_mv = m_valid; o_md = m_data;
        acc = sv && s_ready;
        if (fl) begin
            chk("flush_no_we", {31'd0, o_we}, 32'd0);
            q.delete();
            wp = '0;
        end else begin
            chk("we_is_handshake", {31'd0, o_we}, {31'd0, acc});
            if (acc) begin
                chk("wr_addr", {26'd0, o_addr}, {26'd0, wp});
                chk("wr_din", {24'd0, ram_din}, {24'd0, sd});
                q.push_back(sd);
                wp = wp + 6'd1;
            end
            if (o_mv && mr) begin
                if (q.size() == 0) chk("sb_unexpected_out", 32'd1, 32'd0);
                else chk("sb_data", {24'd0, o_md}, {24'd0, q.pop_front()});
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        wp = '0;
    endtask

    task automatic drain(input string tag, input int maxc);
        int n = 0;
        while (q.size() != 0 && n < maxc) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
            n++;
        end
        chk(tag, q.size(), 32'd0);
    endtask

    initial begin
        // ---- reset state and short burst with m_ready low
        do_reset();
        #1;
        chk("rst_s_ready", {31'd0, s_ready}, 32'd1);
        chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
        chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_m_data", {24'd0, m_data}, 32'h00);

        cyc(1'b1, 8'h11, 1'b0, 1'b0);
        chk("b1_we", {31'd0, o_we}, 32'd1);
        chk("b1_addr", {26'd0, o_addr}, 32'd0);
        chk("b1_mv", {31'd0, o_mv}, 32'd0);
        cyc(1'b1, 8'h22, 1'b0, 1'b0);
        chk("b2_rd_blocks", {31'd0, o_sready}, 32'd0);
        chk("b2_mv", {31'd0, o_mv}, 32'd0);
        cyc(1'b1, 8'h22, 1'b0, 1'b0);
        chk("b3_mv_rise", {31'd0, o_mv}, 32'd1);
        chk("b3_md", {24'd0, o_md}, 32'h11);
        chk("b3_addr", {26'd0, o_addr}, 32'd1);
        cyc(1'b1, 8'h33, 1'b0, 1'b0);
        chk("b4_we", {31'd0, o_we}, 32'd1);
        chk("b4_addr", {26'd0, o_addr}, 32'd2);
        chk("b4_md_hold", {24'd0, o_md}, 32'h11);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk("b5_md_hold", {24'd0, o_md}, 32'h11);
        drain("burst_drain", 20);

        // ---- fill: 70 offered, 65 fit
        do_reset();
        n_in = 0;
        for (int i = 0; i < 80 && n_in < 70; i++) begin
            cyc(1'b1, n_in[7:0], 1'b0, 1'b0);
            if (acc) n_in++;
        end
        chk("fill_accepted", n_in, 32'd65);
        chk("fill_s_ready", {31'd0, o_sready}, 32'd0);
        chk("fill_m_valid", {31'd0, o_mv}, 32'd1);
        chk("fill_head", {24'd0, o_md}, 32'h00);
`ifdef RAM_STREAM_FIFO_LEVEL_EN
        chk("fill_level", {25'd0, level}, 32'd65);
        chk("fill_af", {31'd0, almost_full}, 32'd1);
`endif
        chk("fill_sb_size", q.size(), 32'd65);
        for (int i = 0; i < 65; i++) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
            chk("drain_rate", {31'd0, o_mv}, 32'd1);
        end
        chk("fill_drained", q.size(), 32'd0);

        // ---- concurrent: preload 5, then both sides always active
        do_reset();
        n_in = 0;
        for (int i = 0; i < 20 && n_in < 5; i++) begin
            cyc(1'b1, n_in[7:0], 1'b0, 1'b0);
            if (acc) n_in++;
        end
        for (int i = 0; i < 400; i++) begin
            cyc(1'b1, n_in[7:0], 1'b1, 1'b0);
            chk("alt_we", {31'd0, o_we}, {31'd0, logic'(i % 2 == 1)});
            if (acc) n_in++;
        end
        chk("alt_in_count", n_in, 32'd205);
        drain("alt_drain", 40);

        // ---- wrap: 300 bytes with random valid/ready
        do_reset();
        n_in = 0;
        for (int i = 0; i < 3000 && (n_in < 300 || q.size() != 0); i++) begin
            cyc((n_in < 300) && ($urandom_range(0, 3) != 0), n_in[7:0] ^ 8'h5A,
                $urandom_range(0, 3) != 0, 1'b0);
            if (acc) n_in++;
        end
        chk("wrap_in", n_in, 32'd300);
        chk("wrap_out", q.size(), 32'd0);

        // ---- flush with m_valid=1 and 10 bytes in RAM
        do_reset();
        n_in = 0;
        for (int i = 0; i < 30 && n_in < 11; i++) begin
            cyc(1'b1, 8'h60 + n_in[7:0], 1'b0, 1'b0);
            if (acc) n_in++;
        end
        chk("pre_flush_mv", {31'd0, o_mv}, 32'd1);
`ifdef RAM_STREAM_FIFO_LEVEL_EN
        chk("pre_flush_level", {25'd0, level}, 32'd11);
`endif
        cyc(1'b1, 8'hEE, 1'b1, 1'b1);
        chk("flush_s_ready", {31'd0, o_sready}, 32'd0);
        cyc(1'b1, 8'hA5, 1'b0, 1'b0);
        chk("post_flush_mv", {31'd0, o_mv}, 32'd0);
        chk("post_flush_addr", {26'd0, o_addr}, 32'd0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk("post_flush_first", {24'd0, o_md}, 32'hA5);
        drain("flush_drain", 10);

        // ---- async reset between edges mid-burst
        do_reset();
        for (int i = 0; i < 6; i++) cyc(1'b1, 8'h30 + i[7:0], 1'b0, 1'b0);
        @(negedge clk);
        s_valid = 1'b1; #2;
        rst_n = 1'b0;
        #1;
        chk("arst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("arst_s_ready", {31'd0, s_ready}, 32'd1);
        chk("arst_m_data", {24'd0, m_data}, 32'h00);
`ifdef RAM_STREAM_FIFO_LEVEL_EN
        chk("arst_level", {25'd0, level}, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1; s_valid = 1'b0;
        q.delete();
        wp = '0;
        cyc(1'b1, 8'h5C, 1'b0, 1'b0);
        chk("arst_wr_addr0", {26'd0, o_addr}, 32'd0);
        drain("arst_drain", 10);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
